// File: rtl/unpool_merge.sv
// Merges a 2x nearest-neighbour unpooled coarse stream with a delayed full-resolution skip stream.
// Coarse inputs reach the outputs two cycles later; the skip path runs SKIP_LATENCY cycles ahead.
module unpool_merge #(
    parameter int HEIGHT       = 4,
    parameter int WIDTH        = 8,
    parameter int W_HEIGHT     = 6,
    parameter int W_WIDTH      = 10,
    parameter int UNITS        = 12,
    parameter int INT_BITW     = 5,
    parameter int FRAC_BITW    = 8,
    parameter int SKIP_LATENCY = 3,
    localparam int FB          = INT_BITW + FRAC_BITW,
    localparam int V_BITW      = $clog2(W_HEIGHT),
    localparam int H_BITW      = $clog2(W_WIDTH)
) (
    input  logic                    clock,
    input  logic                    n_rst,
    input  logic                    skip_enable,
    input  logic [0:FB*UNITS-1]     skip_pixels,
    input  logic [V_BITW-1:0]       skip_vcnt,
    input  logic [H_BITW-1:0]       skip_hcnt,
    input  logic                    low_enable,
    input  logic [0:FB*UNITS-1]     low_pixels,
    input  logic [V_BITW-1:0]       low_vcnt,
    input  logic [H_BITW-1:0]       low_hcnt,
    output logic                    out_enable,
    output logic [0:FB*UNITS*2-1]   out_pixels,
    output logic [V_BITW-1:0]       out_vcnt,
    output logic [H_BITW-1:0]       out_hcnt,
    output logic                    out_misalign
);
    localparam int PW     = FB * UNITS;
    localparam int SW     = 1 + V_BITW + H_BITW + PW;
    localparam int PTR_W  = (SKIP_LATENCY > 1) ? $clog2(SKIP_LATENCY) : 1;
    localparam int FILL_W = $clog2(SKIP_LATENCY + 1);
    localparam int LB_AW  = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

    // Skip delay: one shared pointer, each slot is read the cycle before it is overwritten.
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [SW-1:0]     skip_mem [SKIP_LATENCY];
    logic              skip_raw_en, skip_del_en;
    logic [V_BITW-1:0] skip_del_v;
    logic [H_BITW-1:0] skip_del_h;
    logic [PW-1:0]     skip_del_pix;

    assign {skip_raw_en, skip_del_v, skip_del_h, skip_del_pix} = skip_mem[ptr_q];
    assign skip_del_en = skip_raw_en & (fill_q == FILL_W'(SKIP_LATENCY));

    always_ff @(posedge clock) begin
        skip_mem[ptr_q] <= {skip_enable, skip_vcnt, skip_hcnt, skip_pixels};
    end

    // Coarse capture and unpool source selection.
    logic              in_img, capture;
    logic [LB_AW-1:0]  lb_addr;
    logic [PW-1:0]     line_buf [WIDTH / 2];
    logic [PW-1:0]     lb_rd_q;
    logic [PW-1:0]     hold_q, hold_d;
    logic [PW-1:0]     even_pix;

    assign in_img   = (int'(low_vcnt) < HEIGHT) && (int'(low_hcnt) < WIDTH);
    assign capture  = low_enable & in_img & ~low_vcnt[0] & ~low_hcnt[0];
    assign lb_addr  = LB_AW'(low_hcnt >> 1);
    assign even_pix = low_hcnt[0] ? hold_q : low_pixels;

    // Even rows only write, odd rows only read, so read-during-write data is never used.
    always_ff @(posedge clock) begin
        if (capture) begin
            line_buf[lb_addr] <= low_pixels;
        end
        lb_rd_q <= line_buf[lb_addr];
    end

    // Stage 1 and stage 2 registers.
    logic              s1_in_img_q, s1_odd_row_q, s1_skip_en_q;
    logic [PW-1:0]     s1_pix_q, s1_skip_pix_q;
    logic [V_BITW-1:0] s1_vcnt_q, s1_skip_v_q;
    logic [H_BITW-1:0] s1_hcnt_q, s1_skip_h_q;
    logic [PW-1:0]     unpooled;
    logic              out_enable_q, misalign_q, misalign_d;
    logic [2*PW-1:0]   out_pixels_q;
    logic [V_BITW-1:0] out_vcnt_q;
    logic [H_BITW-1:0] out_hcnt_q;

    always_comb begin
        ptr_d  = (ptr_q == PTR_W'(SKIP_LATENCY - 1)) ? '0 : ptr_q + 1'b1;
        fill_d = (fill_q == FILL_W'(SKIP_LATENCY)) ? fill_q : fill_q + 1'b1;
        hold_d = capture ? low_pixels : hold_q;
        unpooled = '0;
        if (s1_in_img_q) begin
            unpooled = s1_odd_row_q ? lb_rd_q : s1_pix_q;
        end
        misalign_d = misalign_q |
                     (s1_skip_en_q & ({s1_skip_v_q, s1_skip_h_q} != {s1_vcnt_q, s1_hcnt_q}));
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q         <= '0;
            fill_q        <= '0;
            hold_q        <= '0;
            s1_in_img_q   <= 1'b0;
            s1_odd_row_q  <= 1'b0;
            s1_pix_q      <= '0;
            s1_vcnt_q     <= '0;
            s1_hcnt_q     <= '0;
            s1_skip_en_q  <= 1'b0;
            s1_skip_v_q   <= '0;
            s1_skip_h_q   <= '0;
            s1_skip_pix_q <= '0;
            out_enable_q  <= 1'b0;
            out_pixels_q  <= '0;
            out_vcnt_q    <= '0;
            out_hcnt_q    <= '0;
            misalign_q    <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            fill_q        <= fill_d;
            hold_q        <= hold_d;
            s1_in_img_q   <= in_img;
            s1_odd_row_q  <= low_vcnt[0];
            s1_pix_q      <= even_pix;
            s1_vcnt_q     <= low_vcnt;
            s1_hcnt_q     <= low_hcnt;
            s1_skip_en_q  <= skip_del_en;
            s1_skip_v_q   <= skip_del_v;
            s1_skip_h_q   <= skip_del_h;
            s1_skip_pix_q <= skip_del_pix;
            out_enable_q  <= s1_skip_en_q & s1_in_img_q;
            out_pixels_q  <= {s1_skip_pix_q, unpooled};
            out_vcnt_q    <= s1_vcnt_q;
            out_hcnt_q    <= s1_hcnt_q;
            misalign_q    <= misalign_d;
        end
    end

    assign out_enable   = out_enable_q;
    assign out_pixels   = out_pixels_q;
    assign out_vcnt     = out_vcnt_q;
    assign out_hcnt     = out_hcnt_q;
    assign out_misalign = misalign_q;

endmodule

// File: tb/tb_unpool_merge.sv
// Bench for unpool_merge: directed frame streams with a scoreboard of expected outputs,
// covering unpool values, skip delay, blanking, sign, misalignment and mid-frame reset.
module tb_unpool_merge;
    localparam int HEIGHT       = 4;
    localparam int WIDTH        = 8;
    localparam int W_HEIGHT     = 6;
    localparam int W_WIDTH      = 10;
    localparam int UNITS        = 12;
    localparam int INT_BITW     = 5;
    localparam int FRAC_BITW    = 8;
    localparam int SKIP_LATENCY = 3;
    localparam int FB           = INT_BITW + FRAC_BITW;
    localparam int PW           = FB * UNITS;
    localparam int V_BITW       = $clog2(W_HEIGHT);
    localparam int H_BITW       = $clog2(W_WIDTH);
    localparam int FRAME        = W_HEIGHT * W_WIDTH;

    logic                clock = 1'b0;
    logic                n_rst = 1'b1;
    logic                skip_enable = 1'b0;
    logic [PW-1:0]       skip_pixels = '0;
    logic [V_BITW-1:0]   skip_vcnt = '0;
    logic [H_BITW-1:0]   skip_hcnt = '0;
    logic                low_enable = 1'b0;
    logic [PW-1:0]       low_pixels = '0;
    logic [V_BITW-1:0]   low_vcnt = '0;
    logic [H_BITW-1:0]   low_hcnt = '0;
    logic                out_enable;
    logic [0:2*PW-1]     out_pixels;
    logic [V_BITW-1:0]   out_vcnt;
    logic [H_BITW-1:0]   out_hcnt;
    logic                out_misalign;

    unpool_merge #(
        .HEIGHT       (HEIGHT),
        .WIDTH        (WIDTH),
        .W_HEIGHT     (W_HEIGHT),
        .W_WIDTH      (W_WIDTH),
        .UNITS        (UNITS),
        .INT_BITW     (INT_BITW),
        .FRAC_BITW    (FRAC_BITW),
        .SKIP_LATENCY (SKIP_LATENCY)
    ) dut (
        .clock        (clock),
        .n_rst        (n_rst),
        .skip_enable  (skip_enable),
        .skip_pixels  (skip_pixels),
        .skip_vcnt    (skip_vcnt),
        .skip_hcnt    (skip_hcnt),
        .low_enable   (low_enable),
        .low_pixels   (low_pixels),
        .low_vcnt     (low_vcnt),
        .low_hcnt     (low_hcnt),
        .out_enable   (out_enable),
        .out_pixels   (out_pixels),
        .out_vcnt     (out_vcnt),
        .out_hcnt     (out_hcnt),
        .out_misalign (out_misalign)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic              en;
        logic [V_BITW-1:0] v;
        logic [H_BITW-1:0] h;
        logic [PW-1:0]     pix;
    } skip_t;

    typedef struct {
        logic              en;
        logic [V_BITW-1:0] v;
        logic [H_BITW-1:0] h;
        logic              mis;
        bit                chk_up;
        logic [PW-1:0]     up;
        logic [PW-1:0]     sk;
    } exp_t;

    skip_t skip_hist [1024];
    exp_t  sb [$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    k, skew, since_rst, rst_frame;
    bit    mis_m;

    function automatic int pv(input int kk);
        return (kk % FRAME) / W_WIDTH;
    endfunction

    function automatic int ph(input int kk);
        return kk % W_WIDTH;
    endfunction

    function automatic bit in_img(input int v, input int h);
        return (v < HEIGHT) && (h < WIDTH);
    endfunction

    // Coarse units: unit0 = 16v+h, last unit = -1.0, the rest a position hash.
    function automatic logic [PW-1:0] cpix(input int fr, input int v, input int h);
        logic [PW-1:0] p;
        logic [FB-1:0] x;
        p = '0;
        for (int u = 0; u < UNITS; u++) begin
            if (u == 0) x = FB'(16 * v + h);
            else if (u == UNITS - 1) x = 13'h1F00;
            else x = FB'(fr * 7 + v * 37 + h * 11 + u * 101);
            p[PW-1-u*FB -: FB] = x;
        end
        return p;
    endfunction

    function automatic logic [PW-1:0] spix(input int kk, input bit sgn);
        logic [PW-1:0] p;
        logic [FB-1:0] x;
        p = '0;
        for (int u = 0; u < UNITS; u++) begin
            if (u == 0) x = sgn ? 13'h1000 : FB'(kk);
            else x = FB'(kk * 13 + u * 29 + 5);
            p[PW-1-u*FB -: FB] = x;
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks();
        chk("rst_out_enable", PW'(out_enable), '0);
        chk("rst_skip_half", out_pixels[0:PW-1], '0);
        chk("rst_unpool_half", out_pixels[PW:2*PW-1], '0);
        chk("rst_out_vcnt", PW'(out_vcnt), '0);
        chk("rst_out_hcnt", PW'(out_hcnt), '0);
        chk("rst_out_misalign", PW'(out_misalign), '0);
    endtask

    // One clock: drive coarse position k and skip position k+skew, queue the expectation,
    // then compare the output belonging to k-2.
    task automatic step();
        exp_t e;
        skip_t s;
        int cv, ch, fr, sv, sh;
        @(posedge clock);
        #1;
        if (!n_rst) begin
            n_rst = 1'b1;
            since_rst = 0;
        end
        cv = pv(k);
        ch = ph(k);
        fr = k / FRAME;
        low_enable = 1'b1;
        low_vcnt   = V_BITW'(cv);
        low_hcnt   = H_BITW'(ch);
        low_pixels = cpix(fr, cv, ch);
        sv = pv(k + skew);
        sh = ph(k + skew);
        s.en  = in_img(sv, sh);
        s.v   = V_BITW'(sv);
        s.h   = H_BITW'(sh);
        s.pix = spix(k, (k >= 2 * FRAME) && (k < 3 * FRAME));
        skip_hist[k] = s;
        skip_enable = s.en;
        skip_vcnt   = s.v;
        skip_hcnt   = s.h;
        skip_pixels = s.pix;

        e.en = 1'b0;
        e.sk = '0;
        if (since_rst >= SKIP_LATENCY) begin
            s = skip_hist[k - SKIP_LATENCY];
            e.en = s.en && in_img(cv, ch);
            e.sk = s.pix;
            if (s.en && ((int'(s.v) != cv) || (int'(s.h) != ch))) mis_m = 1'b1;
        end
        e.v      = V_BITW'(cv);
        e.h      = H_BITW'(ch);
        e.mis    = mis_m;
        e.up     = in_img(cv, ch) ? cpix(fr, cv & ~1, ch & ~1) : '0;
        e.chk_up = !((cv % 2 == 1) && (fr == rst_frame));
        sb.push_back(e);
        k++;
        since_rst++;

        @(negedge clock);
        if (sb.size() > 2) begin
            e = sb.pop_front();
            chk("out_enable", PW'(out_enable), PW'(e.en));
            chk("out_vcnt", PW'(out_vcnt), PW'(e.v));
            chk("out_hcnt", PW'(out_hcnt), PW'(e.h));
            chk("out_misalign", PW'(out_misalign), PW'(e.mis));
            if (e.chk_up) chk("unpool_half", out_pixels[PW:2*PW-1], e.up);
            if (e.en) chk("skip_half", out_pixels[0:PW-1], e.sk);
        end else begin
            chk("enable_after_reset", PW'(out_enable), '0);
        end
    endtask

    task automatic mid_reset(input int fr);
        #1 n_rst = 1'b0;
        #1;
        reset_checks();
        sb.delete();
        mis_m = 1'b0;
        rst_frame = fr;
    endtask

    initial begin
        k = FRAME - SKIP_LATENCY;
        skew = SKIP_LATENCY;
        since_rst = 0;
        rst_frame = -1;
        mis_m = 1'b0;
        #1 n_rst = 1'b0;
        #1;
        reset_checks();

        // Aligned streams; frame 2 carries the negative skip value.
        while (k < 3 * FRAME + 1 * W_WIDTH + 3 + 1) step();
        mid_reset(3);
        while (k < 5 * FRAME) step();

        // Skip stream one cycle further ahead.
        skew = SKIP_LATENCY + 1;
        while (k < 5 * FRAME + 40) step();
        chk("misalign_sticky", PW'(out_misalign), PW'(1));
        mid_reset(5);
        skew = SKIP_LATENCY;
        while (k < 7 * FRAME) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unpool_merge.md
# unpool_merge

Upstream feeder of the integration network. It 2x nearest-neighbour unpools a coarse feature stream produced by the encoder/pooling path. It delays the full-resolution skip feature stream so the two line up. It emits the concatenated 2×UNITS-unit pixel stream that the integration network's first layer consumes. Both halves use the signed fixed-point format INT_BITW.FRAC_BITW, with units packed MSB-first.

## Interface
- HEIGHT, -1, image height in pixels; must be even
- WIDTH, -1, image width in pixels; must be even
- W_HEIGHT, -1, raster window height including blanking
- W_WIDTH, -1, raster window width including blanking
- UNITS, 12, feature units per stream
- INT_BITW, 5, integer bits, sign included
- FRAC_BITW, 8, fraction bits
- SKIP_LATENCY, -1, skip-path delay in cycles; must be ≥1
- FB = INT_BITW+FRAC_BITW, V_BITW = ceil(log2(W_HEIGHT)), H_BITW = ceil(log2(W_WIDTH)) (derived)

Ports:
- clock  in  1  single clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- skip_enable  in  1  skip pixel valid
- skip_pixels  in  [0:FB*UNITS-1]  full-resolution skip features
- skip_vcnt / skip_hcnt  in  V_BITW / H_BITW  skip raster coordinates
- low_enable  in  1  coarse sample valid
- low_pixels  in  [0:FB*UNITS-1]  coarse features, valid at even/even positions
- low_vcnt / low_hcnt  in  V_BITW / H_BITW  coarse raster coordinates; advance every clock over the full window
- out_enable  out  1  merged pixel valid
- out_pixels  out  [0:FB*UNITS*2-1]  {skip features, unpooled features}; skip half in the first FB*UNITS bits
- out_vcnt / out_hcnt  out  V_BITW / H_BITW  output coordinates
- out_misalign  out  1  sticky alignment-error flag

## Operation
- **Skip delay.** {skip_enable, skip_vcnt, skip_hcnt, skip_pixels} is delayed exactly SKIP_LATENCY cycles.
  - Implemented as a circular RAM buffer, depth SKIP_LATENCY.
  - Write and read pointers wrap from SKIP_LATENCY-1 to 0.
  - A fill counter forces the delayed enable to 0 until SKIP_LATENCY entries have been written after reset.
- **Coarse capture.** When low_enable=1, low_vcnt is even, low_hcnt is even, and the position is inside the image:
  - hold register ← low_pixels;
  - line buffer[low_hcnt>>1] ← low_pixels. The line buffer has WIDTH/2 entries.
- **Unpool select** at coarse position (v,h), with v<HEIGHT and h<WIDTH:
  - v even, h even → low_pixels (bypass);
  - v even, h odd → hold register;
  - v odd → line buffer[h>>1].
  - Even rows only write the line buffer and odd rows only read it, so there is no same-address read/write collision.
- **Missing coarse sample.** If low_enable=0 at an even/even in-image position, the hold register and line buffer keep their old values. No flag is raised.
- **Blanking.** Outside the image (v≥HEIGHT or h≥WIDTH):
  - the unpooled half is 0;
  - out_enable is 0.
- **Merge.**
  - out_enable = delayed skip_enable AND in-image.
  - out_pixels = {delayed skip_pixels, unpooled}.
  - out_vcnt/out_hcnt = low_vcnt/low_hcnt delayed to the output stage.
- **Misalign.** out_misalign is set when a delayed skip sample is enabled and its coordinates differ from the coarse coordinates it is paired with.
  - Stays set until reset.
  - The pairing is not corrected.
- **Arithmetic.** None. All data passes bit-exact, sign included.

## Timing
- The coarse stream is presented at cycle t; the result appears at the outputs at t+2.
  - Stage 1: line buffer synchronous read and selection.
  - Stage 2: output register.
- A skip sample entering at cycle c is paired with the coarse position presented at c+SKIP_LATENCY, and appears at c+SKIP_LATENCY+2.
- The delayed skip data is carried through the same 2 pipeline stages.
- Reset, asynchronous:
  - out_enable, out_pixels, out_vcnt, out_hcnt and out_misalign all go to 0 immediately;
  - pointers, fill counter and hold register clear;
  - line buffer contents are not reset.
- After reset release, out_enable stays 0 for at least SKIP_LATENCY+2 cycles.
- Reset mid-frame: the first valid output is produced only once both the skip delay has refilled and a new even row has been captured. The bench must not check unpooled values for odd rows before that point.

## Test plan
Configuration for all scenarios unless stated: WIDTH=8, HEIGHT=4, W_WIDTH=10, W_HEIGHT=6, SKIP_LATENCY=3; streams are aligned, with skip driven 3 cycles ahead of the coarse stream.

1. **Unpool values.** Coarse unit0 = 16v+h at even/even positions.
   - Output row 0 unpooled unit0 = 0,0,2,2,4,4,6,6.
   - Row 1 is identical to row 0.
   - Row 2 = 32,32,34,34,36,36,38,38.
2. **Skip delay.** Skip unit0 = free-running cycle counter; the skip half of the output at cycle t+5 equals the value input at t, for every enabled pixel.
3. **Misalignment.** Skew the skip stream by one extra cycle → out_misalign = 1 at the first enabled output; it stays 1 until n_rst=0 and clears at reset.
4. **Blanking.** At hcnt=8,9 and vcnt=4,5 → out_enable = 0 and unpooled half = 0, while out_vcnt/out_hcnt still track the coarse coordinates.
5. **Reset mid-frame.** Assert n_rst=0 at row 1, h=3.
   - All outputs are 0 in the same cycle.
   - After release, out_enable = 0 for ≥5 cycles.
   - The next frame's unpooled values are correct from row 0.
6. **Sign preservation.** Coarse unit11 = 13'h1F00 (-1.0) and skip unit0 = 13'h1000 (-16.0) → both appear bit-exact in out_pixels, unit11 in all four pixels of its 2×2 block.
